flit_injector: RTL and testbench
================================

# flit_injector

Injection-side network interface for the bufferless (BLESS/CARPOOL) router local port. It queues packet requests from the local core in a small FIFO and presents the head flit (destination, optional multicast destination list, age timestamp, payload) to the router. The router consumes that flit when it grants an injection slot. The unicast destination and multicast list it emits are the fields that the router's route-computation stage decodes into preferred-port vectors. It also raises a starvation flag when the head flit waits too long for a free slot.

## Interface
- DEPTH, 4: request FIFO entries; power of two, ≥2.
- DATA_WIDTH, 32: payload width.
- TIME_WIDTH, 8: age timestamp width.
- STARVE_LIMIT, 16: consecutive ungranted cycles before `starve` asserts; 1..2^8-1.

- clk  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  core offers a request.
- req_ready  out  1  FIFO can accept; transfer when req_valid && req_ready.
- req_dst  in  `DST_WIDTH  unicast destination.
- req_dst_list  in  `DST_LIST_WIDTH  multicast destination bitmap.
- req_mc  in  1  request is multicast.
- req_data  in  DATA_WIDTH  payload.
- inj_grant  in  1  router has a free local-input slot this cycle.
- inj_valid  out  1  head flit present.
- inj_dst  out  `DST_WIDTH  head destination.
- inj_dst_list  out  `DST_LIST_WIDTH  head destination list.
- inj_mc  out  1  head multicast bit.
- inj_time  out  TIME_WIDTH  head timestamp, captured at enqueue.
- inj_data  out  DATA_WIDTH  head payload.
- starve  out  1  head-of-line starvation indicator.
- err_empty_list  out  1  one-cycle pulse when a multicast request with an empty list is dropped.

## Operation
- Storage: circular FIFO with DEPTH entries. Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH. An occupancy counter is log2(DEPTH)+1 bits.
- req_ready = (occupancy != DEPTH). It depends only on registered state, never on inj_grant.
- Enqueue (req_valid && req_ready): write {dst, dst_list, mc, time_now, data} at the write pointer, then advance the write pointer.
- time_now: free-running TIME_WIDTH counter, 0 after reset, +1 every cycle, wraps from all-ones to 0. Age comparisons downstream use modulo arithmetic.
- Dequeue (inj_valid && inj_grant): advance the read pointer. inj_grant while inj_valid=0 is ignored.
- inj_* outputs are driven from the entry at the read pointer. inj_valid = (occupancy != 0). inj_* are don't-care when inj_valid=0.
- Simultaneous enqueue and dequeue: occupancy is unchanged. This is legal at any occupancy where req_ready=1.
- Full: no enqueue, and there is no same-cycle pass-through of a freed entry.
- Empty: there is no bypass; the flit is visible no earlier than the cycle after enqueue.
- Starvation counter (8 bits):
  - cleared on reset, on dequeue, and while empty;
  - otherwise increments each cycle inj_valid && !inj_grant, saturating at STARVE_LIMIT;
  - starve = (counter == STARVE_LIMIT), registered.
- Reset mid-operation: all entries are discarded, pointers, occupancy and counters return to 0, and any in-flight request that cycle is not accepted.

## Timing
- Reset values: req_ready=1, inj_valid=0, starve=0, err_empty_list=0, inj_mc=0; inj_time and time_now=0.
- Latency: a request accepted at edge N is on inj_* with inj_valid=1 after edge N (visible in cycle N+1).
- A dequeue at edge M exposes the next entry in cycle M+1.
- starve rises in the cycle after the STARVE_LIMIT-th consecutive ungranted cycle. It falls in the cycle after the grant.
- req_ready rises one cycle after a dequeue from full.

## Configuration
- CARPOOL_MC_EN defined:
  - multicast is supported; req_dst_list and req_mc are stored and forwarded.
  - A request with req_mc=1 and req_dst_list==0 is accepted (handshake completes) but not enqueued. err_empty_list pulses high in the following cycle.
- CARPOOL_MC_EN undefined:
  - req_mc and req_dst_list are ignored and not stored; inj_mc=0 and inj_dst_list=0 constantly.
  - err_empty_list=0 constantly; all requests enqueue as unicast.

## Test plan
- Reset, then a single request dst=5, data=0xA5A5A5A5 at cycle 3, with inj_grant=1 held -> inj_valid=1 in cycle 4 with inj_dst=5, inj_time=3; inj_valid=0 in cycle 5.
- inj_grant=0, enqueue DEPTH=4 requests -> req_ready=0 after the 4th; a 5th req_valid is not accepted. One grant -> req_ready=1 next cycle; data order is preserved across pointer wrap over 12 requests.
- Full FIFO with simultaneous enqueue attempt and grant -> the enqueue is refused; occupancy goes 4→3. At occupancy 2, simultaneous enqueue and grant -> occupancy stays 2.
- Head waiting with inj_grant=0 for 16 cycles (STARVE_LIMIT=16) -> starve=1 in cycle 17 and held. A grant -> starve=0 the next cycle.
- With CARPOOL_MC_EN, req_mc=1 and dst_list=0 -> handshake completes, no inj_valid, err_empty_list pulses for 1 cycle. Then mc=1, dst_list=0b0110 -> inj_mc=1, inj_dst_list=0b0110.
- time_now wrap: enqueue at time 255 and time 0 (TIME_WIDTH=8) -> inj_time 255 then 0. Reset asserted with 3 entries queued -> inj_valid=0 and req_ready=1 next cycle.

Source files
------------

// File: rtl/flit_injector.sv
// flit_injector: injection-side network interface for a bufferless router's
// local port. Requests from the local core are queued in a DEPTH-entry
// circular FIFO; the head entry is presented to the router as a flit and is
// consumed when the router grants an injection slot. Each flit carries the
// age timestamp taken from a free-running counter at enqueue. A starvation
// flag rises once the head has waited STARVE_LIMIT consecutive ungranted
// cycles.
//
// Optional feature macro: CARPOOL_MC_EN
//   defined   : multicast list and flag are stored and forwarded; a multicast
//               request with an empty list is accepted, dropped, and flagged
//               with a one-cycle err_empty_list pulse.
//   undefined : req_mc/req_dst_list are ignored; inj_mc, inj_dst_list and
//               err_empty_list are held at 0.
//
// Ports:
//   clk, reset        sole clock; synchronous active-high reset
//   req_valid/ready   core request handshake
//   req_dst           unicast destination           (`DST_WIDTH)
//   req_dst_list      multicast destination bitmap  (`DST_LIST_WIDTH)
//   req_mc            request is multicast
//   req_data          payload                       (DATA_WIDTH)
//   inj_grant         router has a free local slot this cycle
//   inj_valid         head flit present
//   inj_dst, inj_dst_list, inj_mc, inj_time, inj_data   head flit fields
//   starve            head-of-line starvation indicator
//   err_empty_list    empty multicast list dropped (one-cycle pulse)

`ifndef DST_WIDTH
`define DST_WIDTH 4
`endif
`ifndef DST_LIST_WIDTH
`define DST_LIST_WIDTH 16
`endif

module flit_injector #(
  parameter int DEPTH        = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int TIME_WIDTH   = 8,
  parameter int STARVE_LIMIT = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [`DST_WIDTH-1:0]      req_dst,
  input  logic [`DST_LIST_WIDTH-1:0] req_dst_list,
  input  logic                       req_mc,
  input  logic [DATA_WIDTH-1:0]      req_data,
  input  logic                       inj_grant,
  output logic                       inj_valid,
  output logic [`DST_WIDTH-1:0]      inj_dst,
  output logic [`DST_LIST_WIDTH-1:0] inj_dst_list,
  output logic                       inj_mc,
  output logic [TIME_WIDTH-1:0]      inj_time,
  output logic [DATA_WIDTH-1:0]      inj_data,
  output logic                       starve,
  output logic                       err_empty_list
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;
  localparam logic [OW-1:0] FULL_OCC   = OW'(DEPTH);
  localparam logic [7:0]    STARVE_MAX = 8'(STARVE_LIMIT);

  logic [AW-1:0]         rd_ptr;
  logic [AW-1:0]         wr_ptr;
  logic [OW-1:0]         occ;
  logic [TIME_WIDTH-1:0] time_now;
  logic [7:0]            starve_cnt;

  logic [`DST_WIDTH-1:0]  mem_dst  [DEPTH];
  logic [TIME_WIDTH-1:0]  mem_time [DEPTH];
  logic [DATA_WIDTH-1:0]  mem_data [DEPTH];

  logic enq_fire;   // handshake completes
  logic enq_write;  // handshake completes and the entry is actually stored
  logic deq_fire;
  logic drop_req;

  // Flow control depends only on registered occupancy, never on inj_grant,
  // so a full FIFO cannot accept in the same cycle it frees an entry.
  assign req_ready = (occ != FULL_OCC);
  assign inj_valid = (occ != '0);
  assign enq_fire  = req_valid && req_ready;
  assign deq_fire  = inj_valid && inj_grant;
  assign enq_write = enq_fire && !drop_req;
  assign starve    = (starve_cnt == STARVE_MAX);

  always_ff @(posedge clk) begin
    if (enq_write) begin
      mem_dst[wr_ptr]  <= req_dst;
      mem_time[wr_ptr] <= time_now;
      mem_data[wr_ptr] <= req_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      occ        <= '0;
      time_now   <= '0;
      starve_cnt <= '0;
    end else begin
      time_now <= time_now + TIME_WIDTH'(1);
      if (enq_write) wr_ptr <= wr_ptr + AW'(1);
      if (deq_fire)  rd_ptr <= rd_ptr + AW'(1);
      case ({enq_write, deq_fire})
        2'b10:   occ <= occ + OW'(1);
        2'b01:   occ <= occ - OW'(1);
        default: ;
      endcase
      // Counts ungranted cycles of the current head only; empty or a
      // dequeue restarts the count for the next head.
      if (deq_fire || !inj_valid) begin
        starve_cnt <= '0;
      end else if (starve_cnt != STARVE_MAX) begin
        starve_cnt <= starve_cnt + 8'd1;
      end
    end
  end

  // Head fields are forced to zero while empty so reset values are defined.
  assign inj_dst  = inj_valid ? mem_dst[rd_ptr]  : '0;
  assign inj_time = inj_valid ? mem_time[rd_ptr] : '0;
  assign inj_data = inj_valid ? mem_data[rd_ptr] : '0;

`ifdef CARPOOL_MC_EN
  logic [`DST_LIST_WIDTH-1:0] mem_list [DEPTH];
  logic                       mem_mc   [DEPTH];
  logic                       err_q;

  assign drop_req = req_mc && (req_dst_list == '0);

  always_ff @(posedge clk) begin
    if (enq_write) begin
      mem_list[wr_ptr] <= req_dst_list;
      mem_mc[wr_ptr]   <= req_mc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= enq_fire && drop_req;
    end
  end

  assign inj_dst_list   = inj_valid ? mem_list[rd_ptr] : '0;
  assign inj_mc         = inj_valid && mem_mc[rd_ptr];
  assign err_empty_list = err_q;
`else
  logic unused_mc_inputs;

  assign unused_mc_inputs = ^{req_mc, req_dst_list};
  assign drop_req         = 1'b0;
  assign inj_dst_list     = '0;
  assign inj_mc           = 1'b0;
  assign err_empty_list   = 1'b0;
`endif

endmodule

// File: tb/tb_flit_injector.sv
// Self-checking bench for flit_injector: a directed vector table, hand-written
// sequences for starvation, multicast handling, timestamp wrap and reset, then
// randomized traffic compared every cycle against a queue-based model.

`ifndef DST_WIDTH
`define DST_WIDTH 4
`endif
`ifndef DST_LIST_WIDTH
`define DST_LIST_WIDTH 16
`endif

module tb_flit_injector;

  localparam int DEPTH = 4;
  localparam int DW    = 32;
  localparam int TW    = 8;
  localparam int SL    = 16;
  localparam int DSTW  = `DST_WIDTH;
  localparam int LW    = `DST_LIST_WIDTH;
`ifdef CARPOOL_MC_EN
  localparam bit MC_EN = 1'b1;
`else
  localparam bit MC_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic            req_valid;
  logic            req_ready;
  logic [DSTW-1:0] req_dst;
  logic [LW-1:0]   req_dst_list;
  logic            req_mc;
  logic [DW-1:0]   req_data;
  logic            inj_grant;
  logic            inj_valid;
  logic [DSTW-1:0] inj_dst;
  logic [LW-1:0]   inj_dst_list;
  logic            inj_mc;
  logic [TW-1:0]   inj_time;
  logic [DW-1:0]   inj_data;
  logic            starve;
  logic            err_empty_list;

  always #5 clk = ~clk;

  flit_injector #(
    .DEPTH(DEPTH),
    .DATA_WIDTH(DW),
    .TIME_WIDTH(TW),
    .STARVE_LIMIT(SL)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_dst(req_dst),
    .req_dst_list(req_dst_list),
    .req_mc(req_mc),
    .req_data(req_data),
    .inj_grant(inj_grant),
    .inj_valid(inj_valid),
    .inj_dst(inj_dst),
    .inj_dst_list(inj_dst_list),
    .inj_mc(inj_mc),
    .inj_time(inj_time),
    .inj_data(inj_data),
    .starve(starve),
    .err_empty_list(err_empty_list)
  );

  // ---------------- reference model ----------------
  typedef struct {
    logic [DSTW-1:0] dst;
    logic [LW-1:0]   list;
    logic            mc;
    logic [TW-1:0]   tm;
    logic [DW-1:0]   data;
  } flit_t;

  flit_t       mq[$];
  int unsigned m_time;
  int unsigned m_wait;
  bit          m_err;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_check();
    check("req_ready", req_ready, mq.size() != DEPTH);
    check("inj_valid", inj_valid, mq.size() != 0);
    check("starve", starve, m_wait == SL);
    check("err_empty_list", err_empty_list, m_err);
    if (mq.size() != 0) begin
      check("inj_dst", inj_dst, mq[0].dst);
      check("inj_time", inj_time, mq[0].tm);
      check("inj_data", inj_data, mq[0].data);
      check("inj_mc", inj_mc, mq[0].mc);
      check("inj_dst_list", inj_dst_list, mq[0].list);
    end else if (!MC_EN) begin
      check("inj_mc_off", inj_mc, 0);
      check("inj_dst_list_off", inj_dst_list, 0);
    end
  endtask

  task automatic model_step();
    bit    valid, enq, deq, drop;
    flit_t f;
    if (reset) begin
      mq.delete();
      m_time = 0;
      m_wait = 0;
      m_err  = 1'b0;
      return;
    end
    valid = (mq.size() != 0);
    deq   = valid && inj_grant;
    enq   = req_valid && (mq.size() < DEPTH);
    drop  = MC_EN && req_mc && (req_dst_list == '0);
    m_err = enq && drop;
    if (deq || !valid) m_wait = 0;
    else if (m_wait < SL) m_wait++;
    if (deq) void'(mq.pop_front());
    if (enq && !drop) begin
      f.dst  = req_dst;
      f.list = MC_EN ? req_dst_list : '0;
      f.mc   = MC_EN && req_mc;
      f.tm   = TW'(m_time);
      f.data = req_data;
      mq.push_back(f);
    end
    m_time = (m_time + 1) % 256;
  endtask

  // Check the current cycle, advance the model, move to the next cycle.
  task automatic tick();
    model_check();
    model_step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit              rv;
    logic [DSTW-1:0] dst;
    bit              gnt;
    bit              e_ready;
    bit              e_valid;
    logic [DSTW-1:0] e_dst;
    logic [TW-1:0]   e_time;
  } vec_t;

  vec_t vt[17];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int accepted;
    // Row k is applied in cycle k after reset; expected values are for cycle k.
    vt = '{
      '{0, 0, 1, 1, 0, 0, 0},   // 0  reset state
      '{0, 0, 1, 1, 0, 0, 0},
      '{0, 0, 1, 1, 0, 0, 0},
      '{1, 5, 1, 1, 0, 0, 0},   // 3  request dst=5
      '{0, 0, 1, 1, 1, 5, 3},   // 4  visible, stamped 3, consumed
      '{0, 0, 0, 1, 0, 0, 0},   // 5  gone
      '{1, 1, 0, 1, 0, 0, 0},   // 6  fill with grant low
      '{1, 2, 0, 1, 1, 1, 6},
      '{1, 3, 0, 1, 1, 1, 6},
      '{1, 4, 0, 1, 1, 1, 6},   // 9  4th accepted
      '{1, 9, 0, 0, 1, 1, 6},   // 10 full: 5th refused
      '{1, 9, 1, 0, 1, 1, 6},   // 11 full + grant: enqueue still refused
      '{0, 0, 1, 1, 1, 2, 7},   // 12 ready back; occupancy 3 -> 2
      '{1, 6, 1, 1, 1, 3, 8},   // 13 enqueue + dequeue at occupancy 2
      '{0, 0, 1, 1, 1, 4, 9},
      '{0, 0, 1, 1, 1, 6, 13},
      '{0, 0, 0, 1, 0, 0, 0}    // 16 drained: occupancy had stayed 2
    };

    reset = 1'b1; req_valid = 1'b0; req_dst = '0; req_dst_list = '0;
    req_mc = 1'b0; req_data = '0; inj_grant = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    mq.delete(); m_time = 0; m_wait = 0; m_err = 1'b0;

    check("reset_inj_mc", inj_mc, 0);
    check("reset_inj_time", inj_time, 0);
    check("reset_starve", starve, 0);
    check("reset_err", err_empty_list, 0);

    for (int i = 0; i < 17; i++) begin
      req_valid = vt[i].rv;
      req_dst   = vt[i].dst;
      req_data  = 32'hA5A5_A5A0 | DW'(vt[i].dst);
      inj_grant = vt[i].gnt;
      check("vec_ready", req_ready, vt[i].e_ready);
      check("vec_valid", inj_valid, vt[i].e_valid);
      if (vt[i].e_valid) begin
        check("vec_dst", inj_dst, vt[i].e_dst);
        check("vec_time", inj_time, vt[i].e_time);
        check("vec_data", inj_data, 32'hA5A5_A5A0 | DW'(vt[i].e_dst));
      end
      tick();
    end
    req_valid = 1'b0; inj_grant = 1'b0;

    // Starvation: 16 ungranted cycles, then held, then cleared by a grant.
    req_valid = 1'b1; req_dst = 7; req_data = 32'h0000_5757;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < SL; i++) begin
      check("starve_wait", starve, 0);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      check("starve_set", starve, 1);
      tick();
    end
    inj_grant = 1'b1;
    check("starve_grant_cycle", starve, 1);
    tick();
    check("starve_clear", starve, 0);
    inj_grant = 1'b0;
    tick();

    // Multicast with an empty list, then a populated list.
    req_valid = 1'b1; req_mc = 1'b1; req_dst_list = '0; req_dst = 3; req_data = 32'h0000_0333;
    check("mc_empty_ready", req_ready, 1);
    tick();
    req_valid = 1'b0; req_mc = 1'b0;
`ifdef CARPOOL_MC_EN
    check("err_pulse", err_empty_list, 1);
    check("mc_empty_dropped", inj_valid, 0);
    tick();
    check("err_pulse_end", err_empty_list, 0);
    check("mc_empty_dropped2", inj_valid, 0);
`else
    check("err_off", err_empty_list, 0);
    check("mc_off_enqueued", inj_valid, 1);
    check("mc_off_dst", inj_dst, 3);
    check("mc_off_flag", inj_mc, 0);
    inj_grant = 1'b1;
    tick();
    inj_grant = 1'b0;
`endif
    req_valid = 1'b1; req_mc = 1'b1; req_dst_list = LW'(6); req_dst = 4; req_data = 32'h0000_0444;
    tick();
    req_valid = 1'b0; req_mc = 1'b0; req_dst_list = '0;
    check("mc_valid", inj_valid, 1);
    check("mc_flag", inj_mc, MC_EN);
    check("mc_list", inj_dst_list, MC_EN ? 6 : 0);
    inj_grant = 1'b1;
    tick();
    inj_grant = 1'b0;

    // Timestamp wrap, then reset with three entries queued.
    for (int i = 0; i < 300 && m_time != 255; i++) tick();
    check("wrap_reached", m_time, 255);
    req_valid = 1'b1; req_dst = 1; req_data = 32'h0000_0F01;
    tick();
    req_dst = 2; req_data = 32'h0000_0F02;
    check("wrap_time_255", inj_time, 255);
    tick();
    req_dst = 3; req_data = 32'h0000_0F03; inj_grant = 1'b1;
    tick();
    inj_grant = 1'b0; req_dst = 4; req_data = 32'h0000_0F04;
    check("wrap_time_0", inj_time, 0);
    tick();
    reset = 1'b1; req_dst = 5; req_data = 32'h0000_0F05;
    tick();
    reset = 1'b0; req_valid = 1'b0;
    check("rst_mid_valid", inj_valid, 0);
    check("rst_mid_ready", req_ready, 1);
    tick();
    check("rst_inflight_dropped", inj_valid, 0);
    tick();

    // Order across pointer wrap: 12 requests under a mixed grant pattern.
    accepted = 0;
    for (int i = 0; i < 100 && accepted < 12; i++) begin
      req_valid = 1'b1;
      req_dst   = DSTW'(accepted);
      req_data  = 32'hC0DE_0000 + DW'(accepted);
      inj_grant = (i % 3) != 0;
      if (req_ready) accepted++;
      tick();
    end
    check("order_all_accepted", accepted, 12);
    req_valid = 1'b0; inj_grant = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) tick();
    inj_grant = 1'b0;

    // Randomized traffic with varying grant pressure and occasional reset.
    for (int i = 0; i < 3000; i++) begin
      int gp;
      case ((i / 300) % 4)
        0:       gp = 10;
        1:       gp = 60;
        2:       gp = 95;
        default: gp = 0;
      endcase
      req_valid    = $urandom_range(0, 99) < 70;
      req_dst      = DSTW'($urandom);
      req_data     = $urandom;
      req_mc       = 1'($urandom_range(0, 1));
      req_dst_list = ($urandom_range(0, 3) == 0) ? '0 : LW'($urandom);
      inj_grant    = $urandom_range(0, 99) < gp;
      reset        = $urandom_range(0, 299) == 0;
      tick();
    end
    reset = 1'b0; req_valid = 1'b0; inj_grant = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
